// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares the single UART TX FIFO write port between NUM_REQ byte-stream requesters.
// Arbitration is round-robin, and it is packet-atomic: once a requester is granted,
// it keeps the port until the byte flagged req_last is accepted.
// The FIFO almost-full flag stalls writes. The grant and the lock are kept while it is high.
//
// Optional feature: define ARB_HOLD_TIMEOUT_EN to release a lock whose owner has
// stopped presenting bytes. The lock is released after TIMEOUT consecutive idle cycles,
// and timeout_flag pulses for one cycle when that happens.
// When ARB_HOLD_TIMEOUT_EN is undefined, a lock is held until req_last is accepted,
// and timeout_flag is tied low.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [8*NUM_REQ-1:0]         req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         fifo_wr_en,
    output logic [7:0]                   fifo_wr_data,
    input  logic                         fifo_almost_full,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic                         timeout_flag
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_r;
    logic [IDW-1:0]   grant_id_r;
    logic [IDW-1:0]   rr_ptr_r;
    logic             busy_r;

    logic             valid_g_s;
    logic             last_g_s;
    logic [7:0]       data_g_s;
    logic             xfer_s;
    logic             any_valid_s;
    logic [IDW-1:0]   pick_s;

    // First valid requester strictly after ptr, wrapping NUM_REQ-1 -> 0.
    // The requester at ptr is checked last, so the one that just finished has lowest priority.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid_v,
                                               input logic [IDW-1:0]     ptr_v);
        logic [IDW-1:0] pick_v;
        logic           found_v;
        int             idx_v;
        pick_v  = '0;
        found_v = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_v = (int'(ptr_v) + k) % NUM_REQ;
            if (!found_v && valid_v[idx_v]) begin
                pick_v  = IDW'(idx_v);
                found_v = 1'b1;
            end else begin
                found_v = found_v;
            end
        end
        return pick_v;
    endfunction

    assign valid_g_s   = req_valid[grant_id_r];
    assign last_g_s    = req_last[grant_id_r];
    assign data_g_s    = req_data[{grant_id_r, 3'b000} +: 8];
    assign any_valid_s = |req_valid;
    assign pick_s      = rr_pick(req_valid, rr_ptr_r);

    // A byte moves whenever the owner has one and the FIFO has room.
    // No byte moves during the reset cycle.
    assign xfer_s = (state_r == ST_LOCKED) && valid_g_s && !fifo_almost_full && !rst;

    // Write port and ready strobe follow the registered grant combinationally.
    always_comb begin
        req_ready = '0;
        if (xfer_s) begin
            req_ready[grant_id_r] = 1'b1;
            fifo_wr_data          = data_g_s;
        end else begin
            req_ready    = '0;
            fifo_wr_data = 8'h00;
        end
    end

    assign fifo_wr_en = xfer_s;
    assign grant_id   = grant_id_r;
    assign busy       = busy_r;

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] idle_cnt_r;
    logic          timeout_flag_r;

    assign timeout_flag = timeout_flag_r;

    // Arbitration FSM with lock timeout: IDLE picks a winner, and LOCKED streams its packet.
    // LOCKED also releases the lock after TIMEOUT consecutive cycles without a valid byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            grant_id_r     <= '0;
            rr_ptr_r       <= IDW'(NUM_REQ - 1);
            busy_r         <= 1'b0;
            idle_cnt_r     <= '0;
            timeout_flag_r <= 1'b0;
        end else begin
            timeout_flag_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    idle_cnt_r <= '0;
                    if (any_valid_s) begin
                        grant_id_r <= pick_s;
                        state_r    <= ST_LOCKED;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (xfer_s && last_g_s) begin
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                        rr_ptr_r   <= grant_id_r;
                        idle_cnt_r <= '0;
                    end else if (!valid_g_s && (idle_cnt_r == IDLE_LAST)) begin
                        state_r        <= ST_IDLE;
                        busy_r         <= 1'b0;
                        rr_ptr_r       <= grant_id_r;
                        idle_cnt_r     <= '0;
                        timeout_flag_r <= 1'b1;
                    end else if (!valid_g_s) begin
                        idle_cnt_r <= idle_cnt_r + CW'(1);
                    end else begin
                        idle_cnt_r <= '0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    idle_cnt_r <= '0;
                end
            endcase
        end
    end
`else
    assign timeout_flag = 1'b0;

    // Arbitration FSM: IDLE picks a winner, and LOCKED streams its packet until req_last is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            grant_id_r <= '0;
            rr_ptr_r   <= IDW'(NUM_REQ - 1);
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_valid_s) begin
                        grant_id_r <= pick_s;
                        state_r    <= ST_LOCKED;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (xfer_s && last_g_s) begin
                        state_r  <= ST_IDLE;
                        busy_r   <= 1'b0;
                        rr_ptr_r <= grant_id_r;
                    end else begin
                        state_r  <= ST_LOCKED;
                        busy_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ=3, TIMEOUT=4).
// A transaction-level reference model tracks the packet owner and the round-robin order.
// The model predicts every output cycle by cycle, and byte logs are compared to the expected FIFO streams.
module tb_uart_tx_arbiter;

    localparam int NREQ = 3;
    localparam int TMO  = 4;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [8*NREQ-1:0]    req_data;
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      req_ready;
    logic                 fifo_wr_en;
    logic [7:0]           fifo_wr_data;
    logic                 fifo_almost_full;
    logic [1:0]           grant_id;
    logic                 busy;
    logic                 timeout_flag;

    uart_tx_arbiter #(.NUM_REQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_last         (req_last),
        .req_ready        (req_ready),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_wr_data     (fifo_wr_data),
        .fifo_almost_full (fifo_almost_full),
        .grant_id         (grant_id),
        .busy             (busy),
        .timeout_flag     (timeout_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: who owns the port, who finished last, idle run length
    bit m_locked = 1'b0;
    int m_owner  = 0;
    int m_ptr    = NREQ - 1;
    int m_idle   = 0;
    bit m_tflag  = 1'b0;

    // requester traffic generators
    bit         g_active [NREQ];
    bit         g_drop   [NREQ];
    int         g_len    [NREQ];
    int         g_idx    [NREQ];
    int         g_reps   [NREQ];
    logic [7:0] g_bytes  [NREQ][4];

    logic [7:0] wr_log[$];
    int         n_pulses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v)
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
        else
            n_pass++;
    endtask

    task automatic load_pkt(input int r, input string s, input int reps);
        g_len[r] = s.len();
        for (int k = 0; k < s.len(); k++) g_bytes[r][k] = s[k];
        g_idx[r]    = 0;
        g_reps[r]   = reps;
        g_active[r] = 1'b1;
        g_drop[r]   = 1'b0;
    endtask

    task automatic gen_drive(input int new_pct, input int drop_pct);
        for (int i = 0; i < NREQ; i++) begin
            if (!g_active[i] && new_pct > 0 && int'($urandom_range(99)) < new_pct) begin
                g_len[i] = int'($urandom_range(1, 4));
                for (int k = 0; k < 4; k++) g_bytes[i][k] = 8'($urandom);
                g_idx[i]    = 0;
                g_reps[i]   = 0;
                g_active[i] = 1'b1;
                g_drop[i]   = 1'b0;
            end
            if (g_active[i] && drop_pct > 0 && int'($urandom_range(99)) < drop_pct)
                g_drop[i] = !g_drop[i];
            req_valid[i]        = g_active[i] && !g_drop[i];
            req_data[8*i +: 8]  = g_active[i] ? g_bytes[i][g_idx[i]] : 8'h00;
            req_last[i]         = g_active[i] && (g_idx[i] == g_len[i] - 1);
        end
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model and the generators.
    task automatic step();
        logic            e_x;
        logic [NREQ-1:0] e_rdy;
        logic [7:0]      e_d;
        bit              n_locked, n_tflag;
        int              n_owner, n_ptr, n_idle;
        @(negedge clk);
        e_x   = !rst && m_locked && req_valid[m_owner] && !fifo_almost_full;
        e_rdy = '0;
        if (e_x) e_rdy[m_owner] = 1'b1;
        e_d   = e_x ? req_data[8*m_owner +: 8] : 8'h00;
        chk("busy",         32'(busy),         32'(m_locked));
        chk("grant_id",     32'(grant_id),     32'(m_owner));
        chk("timeout_flag", 32'(timeout_flag), 32'(m_tflag));
        chk("fifo_wr_en",   32'(fifo_wr_en),   32'(e_x));
        chk("fifo_wr_data", 32'(fifo_wr_data), 32'(e_d));
        chk("req_ready",    32'(req_ready),    32'(e_rdy));
        if (fifo_wr_en === 1'b1) wr_log.push_back(fifo_wr_data);
        if (timeout_flag === 1'b1) n_pulses++;

        n_locked = m_locked; n_owner = m_owner; n_ptr = m_ptr; n_idle = m_idle; n_tflag = 1'b0;
        if (rst) begin
            n_locked = 1'b0; n_owner = 0; n_ptr = NREQ - 1; n_idle = 0;
        end else if (!m_locked) begin
            for (int k = NREQ; k >= 1; k--)
                if (req_valid[(m_ptr + k) % NREQ]) n_owner = (m_ptr + k) % NREQ;
            if (req_valid != '0) n_locked = 1'b1;
            n_idle = 0;
        end else if (e_x && req_last[m_owner]) begin
            n_locked = 1'b0; n_ptr = m_owner; n_idle = 0;
        end
`ifdef ARB_HOLD_TIMEOUT_EN
        else if (!req_valid[m_owner]) begin
            if (m_idle + 1 >= TMO) begin
                n_locked = 1'b0; n_ptr = m_owner; n_idle = 0; n_tflag = 1'b1;
            end else begin
                n_idle = m_idle + 1;
            end
        end else begin
            n_idle = 0;
        end
`endif

        @(posedge clk);
        #1;
        m_locked = n_locked; m_owner = n_owner; m_ptr = n_ptr; m_idle = n_idle; m_tflag = n_tflag;
        for (int i = 0; i < NREQ; i++) begin
            if (rst) begin
                g_idx[i] = 0;
            end else if (e_rdy[i]) begin
                g_idx[i]++;
                if (g_idx[i] == g_len[i]) begin
                    g_idx[i] = 0;
                    if (g_reps[i] > 0) g_reps[i]--;
                    else g_active[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic run_until_idle(input int max_cyc);
        int busy_cnt;
        for (int c = 0; c < max_cyc; c++) begin
            busy_cnt = 0;
            for (int i = 0; i < NREQ; i++) if (g_active[i]) busy_cnt++;
            if (busy_cnt == 0) break;
            gen_drive(0, 0);
            step();
        end
        busy_cnt = 0;
        for (int i = 0; i < NREQ; i++) if (g_active[i]) busy_cnt++;
        chk("drain_timeout", 32'(busy_cnt), 32'd0);
    endtask

    task automatic check_log(input string tag, input string s);
        logic [7:0] got;
        chk({tag, "_len"}, 32'(wr_log.size()), 32'(s.len()));
        for (int k = 0; k < s.len(); k++) begin
            got = (k < wr_log.size()) ? wr_log[k] : 8'hxx;
            chk(tag, 32'(got), 32'(s[k]));
        end
        wr_log.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        gen_drive(0, 0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; fifo_almost_full = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            g_active[i] = 1'b0; g_drop[i] = 1'b0; g_len[i] = 1; g_idx[i] = 0; g_reps[i] = 0;
        end
        n_pulses = 0;
        step();
        step();
        rst = 1'b0;
        wr_log.delete();

        // single one-byte packet from req0
        load_pkt(0, "o", 0);
        run_until_idle(10);
        check_log("t1_stream", "o");

        // simultaneous two-byte packets from reset
        do_reset();
        load_pkt(0, "wo", 0);
        load_pkt(1, "AB", 0);
        run_until_idle(20);
        check_log("t2_stream", "woAB");

        // immediate re-requests alternate
        load_pkt(0, "wo", 2);
        load_pkt(1, "AB", 2);
        run_until_idle(40);
        check_log("t3_stream", "woABwoABwoAB");

        // almost-full for 5 cycles mid-packet
        load_pkt(0, "wxyz", 0);
        gen_drive(0, 0); step();
        gen_drive(0, 0); step();
        fifo_almost_full = 1'b1;
        for (int c = 0; c < 5; c++) begin gen_drive(0, 0); step(); end
        fifo_almost_full = 1'b0;
        run_until_idle(20);
        check_log("t4_stream", "wxyz");

        // reset in the middle of req1's packet
        load_pkt(1, "rs", 0);
        gen_drive(0, 0); step();
        gen_drive(0, 0); step();
        rst = 1'b1;
        gen_drive(0, 0); step();
        rst = 1'b0;
        wr_log.delete();
        load_pkt(0, "pq", 0);
        run_until_idle(20);
        check_log("t5_stream", "pqrs");

        // owner stalls mid-packet while req0 waits
        load_pkt(1, "tu", 0);
        gen_drive(0, 0); step();
        gen_drive(0, 0); step();
        g_drop[1] = 1'b1;
        load_pkt(0, "v", 0);
        n_pulses = 0;
        for (int c = 0; c < 6; c++) begin gen_drive(0, 0); step(); end
        g_drop[1] = 1'b0;
        run_until_idle(20);
`ifdef ARB_HOLD_TIMEOUT_EN
        chk("t6_pulses", 32'(n_pulses), 32'd1);
        check_log("t6_stream", "tvu");
`else
        chk("t6_pulses", 32'(n_pulses), 32'd0);
        check_log("t6_stream", "tuv");
`endif

        // randomized traffic with backpressure, drops and occasional resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            fifo_almost_full = (int'($urandom_range(99)) < 20);
            rst = (int'($urandom_range(999)) < 4);
            gen_drive(30, 10);
            step();
        end
        rst = 1'b0;
        fifo_almost_full = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
